// File: rtl/exs_pkg.sv
// Shared constants and arithmetic helpers for the exs_pipe datapath.
// Helpers work on a fixed maximal width so one definition serves every DATA_WIDTH.
package exs_pkg;

    localparam int unsigned PIPE_DEPTH = 3;
    localparam int unsigned MAX_W      = 64;
    localparam int unsigned MAX_IW     = 2 * MAX_W + 5;

    // Width that holds (a-b)*(3c+1) - 4d exactly for w-bit signed operands.
    function automatic int unsigned inter_width(input int unsigned w);
        return 2 * w + 5;
    endfunction

    function automatic logic signed [MAX_IW-1:0] pos_limit(input int unsigned w);
        return (MAX_IW'(1) <<< (w - 1)) - MAX_IW'(1);
    endfunction

    // The negative limit is the bitwise complement of the positive one.
    function automatic logic sat_ovf(input logic signed [MAX_IW-1:0] x,
                                     input int unsigned             w);
        logic signed [MAX_IW-1:0] hi;
        hi = pos_limit(w);
        return (x > hi) || (x < ~hi);
    endfunction

    // Low bits hold the saturated or wrapped w-bit result.
    function automatic logic [MAX_W-1:0] sat_wrap(input logic signed [MAX_IW-1:0] x,
                                                  input int unsigned             w,
                                                  input logic                    sat_en);
        logic signed [MAX_IW-1:0] hi;
        hi = pos_limit(w);
        if (sat_en && sat_ovf(x, w)) begin
            return x[MAX_IW-1] ? MAX_W'(~hi) : MAX_W'(hi);
        end
        return MAX_W'(x);
    endfunction

endpackage

// File: rtl/exs_sat.sv
// Combinational reduction of the wide quotient to DATA_WIDTH bits with an overflow flag.
module exs_sat
    import exs_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IN_WIDTH   = inter_width(32),
    parameter bit          SAT_EN     = 1'b1
) (
    input  logic signed [IN_WIDTH-1:0]   quot,
    output logic signed [DATA_WIDTH-1:0] res_c,
    output logic                         ovf_c
);

    logic signed [MAX_IW-1:0] quot_ext;

    assign quot_ext = MAX_IW'(quot);
    assign ovf_c    = sat_ovf(quot_ext, DATA_WIDTH);
    assign res_c    = DATA_WIDTH'(sat_wrap(quot_ext, DATA_WIDTH, SAT_EN));

endmodule

// File: rtl/exs_pipe.sv
// Three-stage valid/ready pipeline computing ((a-b)*(3c+1) - 4d)/2 with
// saturate-or-wrap on overflow and a saturating overflow event counter.
module exs_pipe
    import exs_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SAT_EN     = 1,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    input  logic signed [DATA_WIDTH-1:0] c_i,
    input  logic signed [DATA_WIDTH-1:0] d_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic signed [DATA_WIDTH-1:0] q_o,
    output logic                         ovf_o,
    input  logic                         clr_cnt_i,
    output logic [CNT_WIDTH-1:0]         ovf_cnt_o
);

    localparam int unsigned DW = DATA_WIDTH + 1;
    localparam int unsigned TW = DATA_WIDTH + 3;
    localparam int unsigned FW = DATA_WIDTH + 2;
    localparam int unsigned IW = inter_width(DATA_WIDTH);

    logic [PIPE_DEPTH-1:0]       vld;
    logic                        load1_c;
    logic                        load2_c;
    logic                        load3_c;
    logic                        out_xfer_c;

    logic signed [DW-1:0]         diff1;
    logic signed [TW-1:0]         trip1;
    logic signed [FW-1:0]         quad1;
    logic signed [IW-1:0]         prod2;
    logic signed [IW-1:0]         quot_c;
    logic signed [DATA_WIDTH-1:0] sat_q_c;
    logic                         sat_ovf_c;

    // A stage loads when it is empty or its contents move on this cycle.
    assign load3_c    = !vld[2] || ready_i;
    assign load2_c    = !vld[1] || load3_c;
    assign load1_c    = !vld[0] || load2_c;
    assign ready_o    = load1_c;
    assign out_xfer_c = vld[2] && ready_i;
    assign valid_o    = vld[2];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vld <= '0;
        end else begin
            if (load1_c) vld[0] <= valid_i;
            if (load2_c) vld[1] <= vld[0];
            if (load3_c) vld[2] <= vld[1];
        end
    end

    // S1 operand pre-processing; held while idle, no reset needed.
    always_ff @(posedge clk_i) begin
        if (load1_c && valid_i) begin
            diff1 <= DW'(a_i) - DW'(b_i);
            trip1 <= TW'(c_i) * TW'(3) + TW'(1);
            quad1 <= FW'(d_i) <<< 2;
        end
    end

    always_ff @(posedge clk_i) begin
        if (load2_c && vld[0]) begin
            prod2 <= IW'(diff1) * IW'(trip1) - IW'(quad1);
        end
    end

    // Adding 1 to negative values before the arithmetic shift rounds toward zero.
    assign quot_c = (prod2 + (prod2[IW-1] ? IW'(1) : IW'(0))) >>> 1;

    exs_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .IN_WIDTH   (IW),
        .SAT_EN     (SAT_EN != 0)
    ) u_sat (
        .quot  (quot_c),
        .res_c (sat_q_c),
        .ovf_c (sat_ovf_c)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            q_o   <= '0;
            ovf_o <= 1'b0;
        end else if (load3_c && vld[1]) begin
            q_o   <= sat_q_c;
            ovf_o <= sat_ovf_c;
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ovf_cnt_o <= '0;
        end else if (clr_cnt_i) begin
            ovf_cnt_o <= '0;
        end else if (out_xfer_c && ovf_o && (ovf_cnt_o != '1)) begin
            ovf_cnt_o <= ovf_cnt_o + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_exs_pipe.sv
// Bench for exs_pipe: directed steps plus random valid/ready traffic checked
// against a wide-integer reference model and a queue of expected results.
module tb_exs_pipe;

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 16;

    typedef struct {
        logic signed [W-1:0] q;
        logic                ovf;
    } exp_t;

    logic                clk_i = 1'b0;
    logic                rstn_i;
    logic                valid_i;
    logic                ready_o;
    logic signed [W-1:0] a_i, b_i, c_i, d_i;
    logic                valid_o;
    logic                ready_i;
    logic signed [W-1:0] q_o;
    logic                ovf_o;
    logic                clr_cnt_i;
    logic [CW-1:0]       ovf_cnt_o;

    int                  checks = 0;
    int                  errors = 0;
    exp_t                exp_q[$];
    int                  exp_cnt = 0;
    logic                held = 1'b0;
    logic signed [W-1:0] held_q;
    logic                held_ovf;

    localparam logic signed [W-1:0] MAXV = 32'sh7fffffff;
    localparam logic signed [W-1:0] MINV = 32'sh80000000;

    always #5 clk_i = ~clk_i;

    exs_pipe #(
        .DATA_WIDTH (W),
        .SAT_EN     (1),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .a_i       (a_i),
        .b_i       (b_i),
        .c_i       (c_i),
        .d_i       (d_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .q_o       (q_o),
        .ovf_o     (ovf_o),
        .clr_cnt_i (clr_cnt_i),
        .ovf_cnt_o (ovf_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expd);
        checks++;
        assert (obs === expd) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
        end
    endtask

    // Exact result in 128-bit arithmetic; SV signed division truncates toward zero.
    function automatic exp_t model(input logic signed [W-1:0] a, b, c, d);
        logic signed [127:0] x;
        logic signed [127:0] qq;
        exp_t r;
        x     = (128'(a) - 128'(b)) * (128'(c) * 128'sd3 + 128'sd1) - 128'(d) * 128'sd4;
        qq    = x / 128'sd2;
        r.ovf = (qq > 128'sd2147483647) || (qq < -128'sd2147483648);
        if (r.ovf) r.q = (qq < 128'sd0) ? MINV : MAXV;
        else       r.q = qq[31:0];
        return r;
    endfunction

    function automatic logic signed [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return MAXV;
            1:       return MINV;
            2:       return 32'sd0;
            3:       return -32'sd1;
            default: return $signed($urandom());
        endcase
    endfunction

    // One clock cycle: drive, check at negedge, advance models after the edge.
    task automatic cycle(input logic vin, input logic signed [W-1:0] a, b, c, d,
                         input logic rdy, input logic clr, output logic acc);
        logic out_x;
        logic pop_ovf;
        exp_t head;
        valid_i   = vin;
        a_i       = a;
        b_i       = b;
        c_i       = c;
        d_i       = d;
        ready_i   = rdy;
        clr_cnt_i = clr;
        @(negedge clk_i);
        chk("ready_o", 64'(ready_o), 64'((exp_q.size() < 3) || rdy));
        if (held) begin
            chk("hold_valid", 64'(valid_o), 64'(1));
            chk("hold_q", 64'(q_o), 64'(held_q));
            chk("hold_ovf", 64'(ovf_o), 64'(held_ovf));
        end
        acc     = valid_i && ready_o;
        out_x   = valid_o && rdy;
        pop_ovf = 1'b0;
        if (exp_q.size() == 0) begin
            chk("no_stale", 64'(valid_o), 64'(0));
        end else if (valid_o) begin
            head = exp_q[0];
            chk("q_o", 64'(q_o), 64'(head.q));
            chk("ovf_o", 64'(ovf_o), 64'(head.ovf));
            if (out_x) begin
                void'(exp_q.pop_front());
                pop_ovf = head.ovf;
            end
        end
        held     = valid_o && !rdy;
        held_q   = q_o;
        held_ovf = ovf_o;
        @(posedge clk_i);
        #1;
        if (clr) exp_cnt = 0;
        else if (out_x && pop_ovf && exp_cnt < 65535) exp_cnt++;
        chk("ovf_cnt_o", 64'(ovf_cnt_o), 64'(exp_cnt));
        if (acc) exp_q.push_back(model(a, b, c, d));
    endtask

    task automatic idle(input logic rdy, input logic clr);
        logic acc;
        cycle(1'b0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, rdy, clr, acc);
    endtask

    // Single transaction into an empty pipe with ready_i high; checks latency and value.
    task automatic run_one(input string tag, input logic signed [W-1:0] a, b, c, d,
                           input logic signed [W-1:0] eq, input logic eovf);
        logic acc;
        cycle(1'b1, a, b, c, d, 1'b1, 1'b0, acc);
        chk({tag, "_acc"}, 64'(acc), 64'(1));
        chk({tag, "_lat1"}, 64'(valid_o), 64'(0));
        idle(1'b1, 1'b0);
        chk({tag, "_lat2"}, 64'(valid_o), 64'(0));
        idle(1'b1, 1'b0);
        chk({tag, "_lat3"}, 64'(valid_o), 64'(1));
        chk({tag, "_q"}, 64'(q_o), 64'(eq));
        chk({tag, "_ovf"}, 64'(ovf_o), 64'(eovf));
        idle(1'b1, 1'b0);
    endtask

    initial begin
        logic                acc;
        int                  idx;
        int                  n;
        int                  k;
        logic signed [W-1:0] bp_a[5];
        logic signed [W-1:0] bp_b[5];
        logic signed [W-1:0] bp_c[5];
        logic signed [W-1:0] bp_d[5];

        rstn_i    = 1'b0;
        valid_i   = 1'b0;
        ready_i   = 1'b0;
        clr_cnt_i = 1'b0;
        a_i = '0; b_i = '0; c_i = '0; d_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid_o", 64'(valid_o), 64'(0));
        chk("rst_q_o", 64'(q_o), 64'(0));
        chk("rst_ovf_o", 64'(ovf_o), 64'(0));
        chk("rst_cnt", 64'(ovf_cnt_o), 64'(0));
        chk("rst_ready_o", 64'(ready_o), 64'(1));
        rstn_i = 1'b1;

        // Directed values with hand-computed results.
        run_one("basic", 32'sd129, 32'sd1, 32'sd255, 32'sd10, 32'sd49004, 1'b0);
        run_one("neg", 32'sd100, 32'sd200, 32'sd50, 32'sd25, -32'sd7600, 1'b0);
        run_one("trunc", 32'sd0, 32'sd1, 32'sd0, 32'sd0, 32'sd0, 1'b0);
        run_one("ovf_pos", MAXV, -32'sd2147483647, MAXV, -32'sd2147483647, MAXV, 1'b1);
        chk("ovf_cnt1", 64'(ovf_cnt_o), 64'(1));
        run_one("ovf_min", MINV, MINV, MINV, MINV, MAXV, 1'b1);
        chk("ovf_cnt2", 64'(ovf_cnt_o), 64'(2));

        // Backpressure: five non-overflowing inputs, ready_i low for six cycles.
        for (int i = 0; i < 5; i++) begin
            bp_a[i] = $signed($urandom_range(0, 1000)) - 32'sd500;
            bp_b[i] = $signed($urandom_range(0, 1000)) - 32'sd500;
            bp_c[i] = $signed($urandom_range(0, 1000)) - 32'sd500;
            bp_d[i] = $signed($urandom_range(0, 1000)) - 32'sd500;
        end
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            k = (idx < 5) ? idx : 0;
            cycle(idx < 5, bp_a[k], bp_b[k], bp_c[k], bp_d[k], 1'b0, 1'b0, acc);
            chk($sformatf("bp_acc%0d", i), 64'(acc), 64'(i < 3));
            if (acc) idx++;
        end
        chk("bp_accepted", 64'(idx), 64'(3));
        n = 0;
        while ((idx < 5 || exp_q.size() != 0) && n < 40) begin
            k = (idx < 5) ? idx : 0;
            cycle(idx < 5, bp_a[k], bp_b[k], bp_c[k], bp_d[k], 1'b1, 1'b0, acc);
            if (acc) idx++;
            n++;
        end
        chk("bp_all_sent", 64'(idx), 64'(5));
        chk("bp_drain", 64'(exp_q.size()), 64'(0));
        chk("bp_cnt", 64'(ovf_cnt_o), 64'(2));

        // Reset with every stage occupied.
        for (int i = 0; i < 3; i++) cycle(1'b1, pick(), pick(), pick(), pick(), 1'b0, 1'b0, acc);
        chk("full_valid", 64'(valid_o), 64'(1));
        chk("full_ready", 64'(ready_o), 64'(0));
        #2;
        rstn_i  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(valid_o), 64'(0));
        chk("mid_rst_cnt", 64'(ovf_cnt_o), 64'(0));
        chk("mid_rst_q", 64'(q_o), 64'(0));
        chk("mid_rst_ovf", 64'(ovf_o), 64'(0));
        exp_q.delete();
        exp_cnt = 0;
        held    = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("post_rst_ready", 64'(ready_o), 64'(1));
        repeat (6) idle(1'b1, 1'b0);

        // Counter clear in the same cycle as an overflow transfer.
        cycle(1'b1, MINV, MINV, MINV, MINV, 1'b1, 1'b0, acc);
        cycle(1'b1, MINV, MINV, MINV, MINV, 1'b1, 1'b0, acc);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        chk("clr_pre_cnt", 64'(ovf_cnt_o), 64'(1));
        chk("clr_pending_ovf", 64'(valid_o && ovf_o), 64'(1));
        idle(1'b1, 1'b1);
        chk("clr_cnt", 64'(ovf_cnt_o), 64'(0));

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, pick(), pick(), pick(), pick(),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0, acc);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            idle(1'b1, 1'b0);
            n++;
        end
        chk("rand_drain", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exs_pipe.md
EXS_PIPE -- requirements
Module: exs_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand and result width (>= 8).
REQ-002 SHALL have parameter SAT_EN, default 1; 1 = saturate on overflow, 0 = wrap (low DATA_WIDTH bits).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of the overflow event counter.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk_i  input  1  clock (rising edge); rstn_i  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports: valid_i  input  1  input operands valid; ready_o  output  1  block accepts input.
REQ-006 SHALL have ports: a_i, b_i, c_i, d_i  input  DATA_WIDTH each  signed operands.
REQ-007 SHALL have ports: valid_o  output  1  result valid; ready_i  input  1  downstream accepts result.
REQ-008 SHALL have ports: q_o  output  DATA_WIDTH  signed result; ovf_o  output  1  result overflowed, qualified by valid_o.
REQ-009 SHALL have ports: clr_cnt_i  input  1  synchronous counter clear; ovf_cnt_o  output  CNT_WIDTH  overflow count.

Function
REQ-010 SHALL compute q = ((a-b)*(3c+1) - 4d)/2 exactly, in 2*DATA_WIDTH+5-bit signed arithmetic, with no intermediate loss.
REQ-011 SHALL divide by 2 truncating toward zero (e.g. -1/2 = 0, -3/2 = -1).
REQ-012 SHALL set ovf_o=1 when the exact quotient lies outside [-2^(W-1), 2^(W-1)-1].
REQ-013 SHALL, when overflowed, output 2^(W-1)-1 (positive) or -2^(W-1) (negative) if SAT_EN=1; otherwise output the low W bits.
REQ-014 SHALL keep valid_o=1 for overflowed results; overflow is flagged, never dropped.
REQ-015 SHALL be a 3-stage pipeline: S1 registers a-b, 3c+1, 4d; S2 registers the product minus 4d; S3 registers q_o and ovf_o.
REQ-016 SHALL transfer input when valid_i && ready_o, and output when valid_o && ready_i.
REQ-017 SHALL have latency 3 cycles from input transfer to valid_o with ready_i held high, and throughput 1 per cycle.
REQ-018 SHALL let each stage load when it is empty or its contents are advancing; ready_o = !S1_valid || S1 advancing (same-cycle pass-through of ready_i, no skid buffer).
REQ-019 SHALL, with ready_i low, hold q_o, ovf_o and valid_o stable and absorb up to 3 transactions before deasserting ready_o.
REQ-020 SHALL preserve order with no loss or duplication under any valid/ready pattern.
REQ-021 SHALL increment ovf_cnt_o on each output transfer with ovf_o=1, saturating at 2^CNT_WIDTH-1.
REQ-022 SHALL give clr_cnt_i priority over a same-cycle increment, so the counter reads 0 on the next cycle.
REQ-023 SHALL ignore data inputs when valid_i=0; S1 operand registers need not change.

Reset
REQ-024 SHALL, on rstn_i low, immediately clear all stage valids, valid_o, ovf_o, q_o and ovf_cnt_o to 0.
REQ-025 SHALL discard in-flight transactions on a reset mid-operation; ready_o=1 on the first cycle after release.
REQ-026 SHALL reset only the valid and control flops asynchronously; datapath operand registers may be reset-free, except q_o.

Structure
REQ-027 SHALL place in package exs_pkg: the pipeline-depth constant (3), the intermediate-width function (2*W+5), and the saturate/wrap helper function.
REQ-028 SHALL use one sub-module, exs_sat, combinational: W-bit saturate/wrap of the wide quotient plus the ovf flag; the pipeline control stays in exs_pipe.

Verification
REQ-029 SHALL check: a=129, b=1, c=255, d=10, ready_i=1 -> q_o=49004, ovf_o=0, valid_o exactly 3 cycles after the transfer.
REQ-030 SHALL check: a=100, b=200, c=50, d=25 -> q_o=-7600; and a=0, b=1, c=0, d=0 -> q_o=0 (truncation toward zero).
REQ-031 SHALL check: a=2147483647, b=-2147483647, c=2147483647, d=-2147483647 with SAT_EN=1 -> q_o=2147483647, ovf_o=1, ovf_cnt_o=1; a=b=c=d=-2^31 -> q_o=2147483647, ovf_o=1, ovf_cnt_o=2.
REQ-032 SHALL check: 5 back-to-back inputs with ready_i=0 for 6 cycles -> ready_o low after 3 accepted; after ready_i rises, all 5 results arrive in order, unchanged.
REQ-033 SHALL check: rstn_i pulsed low with all stages full -> valid_o and ovf_cnt_o read 0 before the next clk_i edge; no stale result emitted after release.
REQ-034 SHALL check: clr_cnt_i in the same cycle as an overflow transfer -> ovf_cnt_o=0 the next cycle.
